addr_mult_pipe: RTL and testbench

- Parametrised, pipelined unsigned address multiplier; the next generation of the A-register multiply unit.
- Adds per-operation valid and destination-tag tracking, a pipeline hold, and overflow detection.
- Latency is WIDTH/BITS_PER_STAGE cycles; one operation can be accepted per cycle.
- Feeds the address-result writeback path, which uses o_tag to select the destination A register.

---
 rtl/addr_mult_pkg.sv | 21 ++
 rtl/addr_mult_stage.sv | 81 ++++++++
 rtl/addr_mult_pipe.sv | 84 ++++++++
 tb/tb_addr_mult_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_mult_pkg.sv
// Shared constants, latency helper and stage payload type for the pipelined
// address multiplier.
package addr_mult_pkg;

  localparam int ADDR_W     = 24;
  localparam int ADDR_TAG_W = 3;

  // One pipeline stage retires bps multiplier bits, so the depth is width/bps.
  function automatic int mult_lat(input int width, input int bps);
    return width / bps;
  endfunction

  typedef struct packed {
    logic [2*ADDR_W-1:0]   sum;
    logic [ADDR_W-1:0]     aj;
    logic [ADDR_W-1:0]     ak;
    logic [ADDR_TAG_W-1:0] tag;
    logic                  valid;
  } addr_mult_payload_t;

endpackage

// File: rtl/addr_mult_stage.sv
// One multiplier pipeline stage: folds BPS multiplier bits into the running
// sum and registers the payload under hold and synchronous reset.
module addr_mult_stage
  import addr_mult_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int BPS   = 4,
  parameter int TAG_W = ADDR_TAG_W,
  parameter int STAGE = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               valid_i,
  input  logic [2*WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0]   aj_i,
  input  logic [WIDTH-1:0]   ak_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0]   aj_o,
  output logic [WIDTH-1:0]   ak_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic [2*WIDTH-1:0] sum_d;
  logic [2*WIDTH-1:0] sum_q;
  logic [WIDTH-1:0]   aj_q;
  logic [WIDTH-1:0]   ak_q;
  logic [TAG_W-1:0]   tag_q;
  logic               valid_q;
  logic               loadData;
  logic [BPS-1:0]     ajBits;
  logic [2*WIDTH-1:0] addend;

  // Walk the multiplier slice LSB first, doubling the shifted multiplicand.
  always_comb begin
    sum_d  = sum_i;
    ajBits = aj_i[STAGE*BPS +: BPS];
    addend = {{WIDTH{1'b0}}, ak_i} << (STAGE*BPS);
    for (int b = 0; b < BPS; b++) begin
      if (ajBits[0]) begin
        sum_d = sum_d + addend;
      end
      ajBits = ajBits >> 1;
      addend = addend << 1;
    end
  end

  // The last stage doubles as the output register, so its data only moves
  // when a valid operation arrives; earlier stages load unconditionally.
  assign loadData = !hold_i && (valid_i || !LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      aj_q    <= '0;
      ak_q    <= '0;
      tag_q   <= '0;
    end else begin
      if (!hold_i) begin
        valid_q <= valid_i;
      end
      if (loadData) begin
        sum_q <= sum_d;
        aj_q  <= aj_i;
        ak_q  <= ak_i;
        tag_q <= tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign aj_o    = aj_q;
  assign ak_o    = ak_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/addr_mult_pipe.sv
// Pipelined unsigned address multiplier with tag/valid tracking, pipeline
// hold and overflow detection; latency WIDTH/BITS_PER_STAGE cycles.
module addr_mult_pipe
  import addr_mult_pkg::*;
#(
  parameter int WIDTH          = ADDR_W,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = ADDR_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_aj,
  input  logic [WIDTH-1:0] i_ak,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_hold,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow,
  output logic [TAG_W-1:0] o_tag
);

  localparam int LAT = mult_lat(WIDTH, BITS_PER_STAGE);

  if (WIDTH % BITS_PER_STAGE != 0) begin : g_cfgCheck
    $error("addr_mult_pipe: WIDTH must be a multiple of BITS_PER_STAGE");
  end

  logic               inValid    [LAT];
  logic [2*WIDTH-1:0] inSum      [LAT];
  logic [WIDTH-1:0]   inAj       [LAT];
  logic [WIDTH-1:0]   inAk       [LAT];
  logic [TAG_W-1:0]   inTag      [LAT];
  logic               stageValid [LAT];
  logic [2*WIDTH-1:0] stageSum   [LAT];
  logic [WIDTH-1:0]   stageAj    [LAT];
  logic [WIDTH-1:0]   stageAk    [LAT];
  logic [TAG_W-1:0]   stageTag   [LAT];

  // Stage 0 starts from a zero sum on the issue port; later stages chain.
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign inValid[s] = i_valid;
      assign inSum[s]   = '0;
      assign inAj[s]    = i_aj;
      assign inAk[s]    = i_ak;
      assign inTag[s]   = i_tag;
    end else begin : g_chain
      assign inValid[s] = stageValid[s-1];
      assign inSum[s]   = stageSum[s-1];
      assign inAj[s]    = stageAj[s-1];
      assign inAk[s]    = stageAk[s-1];
      assign inTag[s]   = stageTag[s-1];
    end

    addr_mult_stage #(
      .WIDTH (WIDTH),
      .BPS   (BITS_PER_STAGE),
      .TAG_W (TAG_W),
      .STAGE (s),
      .LAST  (s == LAT - 1)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .hold_i  (i_hold),
      .valid_i (inValid[s]),
      .sum_i   (inSum[s]),
      .aj_i    (inAj[s]),
      .ak_i    (inAk[s]),
      .tag_i   (inTag[s]),
      .valid_o (stageValid[s]),
      .sum_o   (stageSum[s]),
      .aj_o    (stageAj[s]),
      .ak_o    (stageAk[s]),
      .tag_o   (stageTag[s])
    );
  end

  assign o_valid    = stageValid[LAT-1];
  assign o_result   = stageSum[LAT-1][WIDTH-1:0];
  assign o_overflow = |stageSum[LAT-1][2*WIDTH-1:WIDTH];
  assign o_tag      = stageTag[LAT-1];

endmodule

// File: tb/tb_addr_mult_pipe.sv
// Bench for addr_mult_pipe: a 24/4 and a 32/8 instance, each with an
// in-order expected-result queue drained by a negedge monitor.
module tb_addr_mult_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [2:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        vldA, vldB;
  logic [23:0] ajA, akA;
  logic [31:0] ajB, akB;
  logic [2:0]  tagA, tagB;
  logic        oValidA, oValidB;
  logic [23:0] oResultA;
  logic [31:0] oResultB;
  logic        oOvfA, oOvfB;
  logic [2:0]  oTagA, oTagB;

  int   nCompared;
  int   nMismatched;
  int   cyc;
  int   lastIssueCyc;
  exp_t qA[$];
  exp_t qB[$];
  exp_t expA, expB;

  addr_mult_pipe #(.WIDTH(24), .BITS_PER_STAGE(4), .TAG_W(3)) dutA (
    .clk(clk), .rst(rst), .i_valid(vldA), .i_aj(ajA), .i_ak(akA), .i_tag(tagA),
    .i_hold(hold), .o_valid(oValidA), .o_result(oResultA), .o_overflow(oOvfA),
    .o_tag(oTagA)
  );

  addr_mult_pipe #(.WIDTH(32), .BITS_PER_STAGE(8), .TAG_W(3)) dutB (
    .clk(clk), .rst(rst), .i_valid(vldB), .i_aj(ajB), .i_ak(akB), .i_tag(tagB),
    .i_hold(hold), .o_valid(oValidB), .o_result(oResultB), .o_overflow(oOvfB),
    .o_tag(oTagB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int w, input logic [2:0] t);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] mask;
    p     = {32'd0, a} * {32'd0, b};
    mask  = (64'd1 << w) - 64'd1;
    e.res = 32'(p & mask);
    e.ovf = (p >> w) != 64'd0;
    e.tag = t;
    return e;
  endfunction

  function automatic logic [31:0] randOp();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // Drives one issue for a single edge (hold must be low) and queues the result.
  task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] t, input logic [31:0] expRes,
                               input logic expOvf);
    exp_t e;
    e.res = expRes;
    e.ovf = expOvf;
    e.tag = t;
    if (which == 0) begin
      vldA = 1'b1; ajA = a[23:0]; akA = b[23:0]; tagA = t;
      qA.push_back(e);
    end else begin
      vldB = 1'b1; ajB = a; akB = b; tagB = t;
      qB.push_back(e);
    end
    @(posedge clk); #1;
    lastIssueCyc = cyc;
    vldA = 1'b0;
    vldB = 1'b0;
  endtask

  task automatic waitValid(input int which, input int expLat, input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (((which == 0) ? oValidA : oValidB) === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput({name, " seen"}, 64'(found), 64'd1);
    if (found) checkOutput({name, " latency"}, 64'(cyc - lastIssueCyc + 1), 64'(expLat));
  endtask

  always @(negedge clk) begin
    if (oValidA === 1'b1 && hold === 1'b0) begin
      if (qA.size() == 0) begin
        checkOutput("A unexpected o_valid", 64'(oValidA), 64'd0);
      end else begin
        expA = qA.pop_front();
        checkOutput("A o_result", 64'(oResultA), 64'(expA.res));
        checkOutput("A o_overflow", 64'(oOvfA), 64'(expA.ovf));
        checkOutput("A o_tag", 64'(oTagA), 64'(expA.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (oValidB === 1'b1 && hold === 1'b0) begin
      if (qB.size() == 0) begin
        checkOutput("B unexpected o_valid", 64'(oValidB), 64'd0);
      end else begin
        expB = qB.pop_front();
        checkOutput("B o_result", 64'(oResultB), 64'(expB.res));
        checkOutput("B o_overflow", 64'(oOvfB), 64'(expB.ovf));
        checkOutput("B o_tag", 64'(oTagB), 64'(expB.tag));
      end
    end
  end

  initial begin
    int   accA;
    int   accB;
    int   guard;
    logic [31:0] ra, rb;
    logic [2:0]  rt;

    nCompared = 0;
    nMismatched = 0;
    rst = 1'b1; hold = 1'b0;
    vldA = 1'b0; ajA = '0; akA = '0; tagA = '0;
    vldB = 1'b0; ajB = '0; akB = '0; tagB = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("A reset o_valid", 64'(oValidA), 64'd0);
    checkOutput("A reset o_result", 64'(oResultA), 64'd0);
    checkOutput("A reset o_overflow", 64'(oOvfA), 64'd0);
    checkOutput("A reset o_tag", 64'(oTagA), 64'd0);
    checkOutput("B reset o_valid", 64'(oValidB), 64'd0);
    checkOutput("B reset o_result", 64'(oResultB), 64'd0);

    $display("[TB] single op 3*5");
    applyStimulus(0, 32'd3, 32'd5, 3'd2, 32'h00000F, 1'b0);
    waitValid(0, 6, "single");
    @(posedge clk); #1;
    checkOutput("single o_valid pulse ends", 64'(oValidA), 64'd0);

    $display("[TB] overflow boundaries");
    applyStimulus(0, 32'hFFFFFF, 32'hFFFFFF, 3'd1, 32'h000001, 1'b1);
    applyStimulus(0, 32'h001000, 32'h001000, 3'd2, 32'h000000, 1'b1);
    applyStimulus(0, 32'h000FFF, 32'h001000, 3'd3, 32'hFFF000, 1'b0);
    applyStimulus(0, 32'h000000, 32'hABCDEF, 3'd4, 32'h000000, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] back-to-back issue");
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 32'(k), 32'h10, 3'(k), 32'(k * 16), 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      checkOutput("b2b o_valid run", 64'(oValidA), 64'd1);
      @(posedge clk); #1;
    end
    checkOutput("b2b o_valid after run", 64'(oValidA), 64'd0);

    $display("[TB] hold stretches latency");
    applyStimulus(0, 32'd7, 32'd9, 3'd5, 32'h3F, 1'b0);
    @(posedge clk); #1;
    hold = 1'b1;
    vldA = 1'b1; ajA = 24'd2; akA = 24'd2; tagA = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    vldA = 1'b0;
    waitValid(0, 9, "hold");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkOutput("hold issue dropped", 64'(oValidA), 64'd0);
    end

    $display("[TB] hold while o_valid is presented");
    applyStimulus(0, 32'h55, 32'd3, 3'd4, 32'hFF, 1'b0);
    waitValid(0, 6, "held output");
    hold = 1'b1;
    @(posedge clk); #1;
    checkOutput("held o_valid 1", 64'(oValidA), 64'd1);
    checkOutput("held o_result", 64'(oResultA), 64'hFF);
    @(posedge clk); #1;
    checkOutput("held o_valid 2", 64'(oValidA), 64'd1);
    hold = 1'b0;
    @(posedge clk); #1;
    checkOutput("released o_valid", 64'(oValidA), 64'd0);
    checkOutput("retained o_result", 64'(oResultA), 64'hFF);
    checkOutput("retained o_tag", 64'(oTagA), 64'd4);

    $display("[TB] reset with ops in flight");
    applyStimulus(0, 32'd11, 32'd13, 3'd1, 32'd143, 1'b0);
    applyStimulus(0, 32'd17, 32'd19, 3'd2, 32'd323, 1'b0);
    applyStimulus(0, 32'd23, 32'd29, 3'd3, 32'd667, 1'b0);
    rst = 1'b1;
    vldA = 1'b1; ajA = 24'd4; akA = 24'd4; tagA = 3'd6;
    qA.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    vldA = 1'b0;
    checkOutput("post-reset o_valid", 64'(oValidA), 64'd0);
    checkOutput("post-reset o_result", 64'(oResultA), 64'd0);
    checkOutput("post-reset o_overflow", 64'(oOvfA), 64'd0);
    checkOutput("post-reset o_tag", 64'(oTagA), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checkOutput("flushed op silent", 64'(oValidA), 64'd0);
    end
    applyStimulus(0, 32'h123, 32'h10, 3'd3, 32'h1230, 1'b0);
    waitValid(0, 6, "after reset");

    $display("[TB] 32-bit / 8-bit configuration");
    applyStimulus(1, 32'h10000, 32'h10000, 3'd5, 32'h0, 1'b1);
    waitValid(1, 4, "wide");
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] random traffic on both configurations");
    accA = 0;
    accB = 0;
    guard = 0;
    while ((accA < 1000 || accB < 1000) && guard < 5000) begin
      hold = ($urandom_range(0, 9) == 0);
      ra = randOp(); rb = randOp(); rt = 3'($urandom);
      vldA = (accA < 1000) && ($urandom_range(0, 3) != 0);
      ajA = ra[23:0]; akA = rb[23:0]; tagA = rt;
      if (vldA && !hold) begin
        qA.push_back(model({8'd0, ra[23:0]}, {8'd0, rb[23:0]}, 24, rt));
        accA++;
      end
      ra = randOp(); rb = randOp(); rt = 3'($urandom);
      vldB = (accB < 1000) && ($urandom_range(0, 3) != 0);
      ajB = ra; akB = rb; tagB = rt;
      if (vldB && !hold) begin
        qB.push_back(model(ra, rb, 32, rt));
        accB++;
      end
      @(posedge clk); #1;
      guard++;
    end
    hold = 1'b0;
    vldA = 1'b0;
    vldB = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("A random ops issued", 64'(accA), 64'd1000);
    checkOutput("B random ops issued", 64'(accB), 64'd1000);
    checkOutput("A queue drained", 64'(qA.size()), 64'd0);
    checkOutput("B queue drained", 64'(qB.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
